// File: rtl/clock24_time_counter.sv
`default_nettype none
// ============================================================================
//  Module      : clock24_time_counter
//  Description : 24-hour time base. Divides clk to a 1 Hz tick and keeps
//                hours/minutes/seconds in binary, with a button-driven set
//                mode (RUN -> SET_H -> SET_M -> SET_S) and a preset load.
//  Revision    : 1.0 - initial release
// ============================================================================
module clock24_time_counter #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       mode_btn,
    input  logic       inc_btn,
    input  logic       load,
    input  logic [4:0] load_h,
    input  logic [5:0] load_m,
    input  logic [5:0] load_s,
    output logic [4:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic [1:0] mode,
    output logic       sec_tick,
    output logic       day_wrap,
    output logic       load_err
);

    localparam int            PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0] C_TERM    = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        MODE_RUN   = 2'd0,
        MODE_SET_H = 2'd1,
        MODE_SET_M = 2'd2,
        MODE_SET_S = 2'd3
    } mode_t;

    mode_t         mode_q,     mode_d;
    logic [PW-1:0] presc_q,    presc_d;
    logic [4:0]    hours_q,    hours_d;
    logic [5:0]    minutes_q,  minutes_d;
    logic [5:0]    seconds_q,  seconds_d;
    logic          sec_tick_q, sec_tick_d;
    logic          day_wrap_q, day_wrap_d;
    logic          load_err_q, load_err_d;

    logic       w_load_ok;
    logic [4:0] w_h_inc;
    logic [5:0] w_m_inc;
    logic [5:0] w_s_inc;
    logic       w_s_top;
    logic       w_m_top;
    logic       w_h_top;

    assign w_load_ok = (load_h <= 5'd23) && (load_m <= 6'd59) && (load_s <= 6'd59);
    assign w_s_top   = (seconds_q == 6'd59);
    assign w_m_top   = (minutes_q == 6'd59);
    assign w_h_top   = (hours_q == 5'd23);
    assign w_h_inc   = w_h_top ? 5'd0 : hours_q + 5'd1;
    assign w_m_inc   = w_m_top ? 6'd0 : minutes_q + 6'd1;
    assign w_s_inc   = w_s_top ? 6'd0 : seconds_q + 6'd1;

    // Next-state: one action per cycle, chosen as load > mode_btn > inc_btn > tick.
    always_comb begin
        mode_d     = mode_q;
        presc_d    = presc_q;
        hours_d    = hours_q;
        minutes_d  = minutes_q;
        seconds_d  = seconds_q;
        sec_tick_d = 1'b0;
        day_wrap_d = 1'b0;
        load_err_d = 1'b0;

        if (load) begin
            // A rejected preset freezes the whole cycle, prescaler included,
            // so a pending tick simply lands one cycle later.
            if (w_load_ok) begin
                hours_d   = load_h;
                minutes_d = load_m;
                seconds_d = load_s;
                presc_d   = '0;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (mode_btn) begin
            unique case (mode_q)
                MODE_RUN:   mode_d = MODE_SET_H;
                MODE_SET_H: mode_d = MODE_SET_M;
                MODE_SET_M: mode_d = MODE_SET_S;
                MODE_SET_S: mode_d = MODE_RUN;
                default:    mode_d = MODE_RUN;
            endcase
            // Prescaler is 0 in every set state and restarts cleanly on exit.
            presc_d = '0;
        end else if (inc_btn && (mode_q != MODE_RUN)) begin
            unique case (mode_q)
                MODE_SET_H: hours_d   = w_h_inc;
                MODE_SET_M: minutes_d = w_m_inc;
                MODE_SET_S: seconds_d = w_s_inc;
                default:    ;
            endcase
        end else if (mode_q == MODE_RUN) begin
            if (presc_q == C_TERM) begin
                presc_d    = '0;
                sec_tick_d = 1'b1;
                seconds_d  = w_s_inc;
                if (w_s_top) begin
                    minutes_d = w_m_inc;
                    if (w_m_top) begin
                        hours_d    = w_h_inc;
                        day_wrap_d = w_h_top;
                    end
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    // State and output registers; asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_q     <= MODE_RUN;
            presc_q    <= '0;
            hours_q    <= '0;
            minutes_q  <= '0;
            seconds_q  <= '0;
            sec_tick_q <= 1'b0;
            day_wrap_q <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            presc_q    <= presc_d;
            hours_q    <= hours_d;
            minutes_q  <= minutes_d;
            seconds_q  <= seconds_d;
            sec_tick_q <= sec_tick_d;
            day_wrap_q <= day_wrap_d;
            load_err_q <= load_err_d;
        end
    end

    assign hours    = hours_q;
    assign minutes  = minutes_q;
    assign seconds  = seconds_q;
    assign mode     = mode_q;
    assign sec_tick = sec_tick_q;
    assign day_wrap = day_wrap_q;
    assign load_err = load_err_q;

endmodule
`default_nettype wire

// File: tb/tb_clock24_time_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clock24_time_counter
//  Description : Self-checking bench for clock24_time_counter (TICK_DIV=4).
//                Reference model tracks time as seconds-of-day.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_clock24_time_counter;

    localparam int C_DIV = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       mode_btn = 1'b0;
    logic       inc_btn = 1'b0;
    logic       load = 1'b0;
    logic [4:0] load_h = '0;
    logic [5:0] load_m = '0;
    logic [5:0] load_s = '0;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic [1:0] mode;
    logic       sec_tick;
    logic       day_wrap;
    logic       load_err;

    int total = 0;
    int bad   = 0;

    // reference model state
    int t_sod  = 0;   // seconds of day
    int m_mode = 0;
    int m_pc   = 0;
    int m_tick = 0;
    int m_wrap = 0;
    int m_err  = 0;

    int n_tick;
    int n_wrap;
    int last_tick;
    int cyc_no;

    clock24_time_counter #(.TICK_DIV(C_DIV)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .mode_btn (mode_btn),
        .inc_btn  (inc_btn),
        .load     (load),
        .load_h   (load_h),
        .load_m   (load_m),
        .load_s   (load_s),
        .hours    (hours),
        .minutes  (minutes),
        .seconds  (seconds),
        .mode     (mode),
        .sec_tick (sec_tick),
        .day_wrap (day_wrap),
        .load_err (load_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input int exp_v);
        total++;
        assert (obs === 32'(exp_v)) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic chk_all(input string where);
        chk({where, ".hours"},    32'(hours),    t_sod / 3600);
        chk({where, ".minutes"},  32'(minutes),  (t_sod / 60) % 60);
        chk({where, ".seconds"},  32'(seconds),  t_sod % 60);
        chk({where, ".mode"},     32'(mode),     m_mode);
        chk({where, ".sec_tick"}, 32'(sec_tick), m_tick);
        chk({where, ".day_wrap"}, 32'(day_wrap), m_wrap);
        chk({where, ".load_err"}, 32'(load_err), m_err);
    endtask

    task automatic model_reset();
        t_sod = 0; m_mode = 0; m_pc = 0; m_tick = 0; m_wrap = 0; m_err = 0;
    endtask

    // Apply one clock edge to the model given the inputs presented before it.
    task automatic model_step(input bit mb, input bit ib, input bit ld,
                              input int lh, input int lm, input int ls);
        int h, m, s;
        m_tick = 0; m_wrap = 0; m_err = 0;
        if (ld) begin
            if (lh <= 23 && lm <= 59 && ls <= 59) begin
                t_sod = lh * 3600 + lm * 60 + ls;
                m_pc  = 0;
            end else begin
                m_err = 1;
            end
        end else if (mb) begin
            m_mode = (m_mode + 1) % 4;
            m_pc   = 0;
        end else if (ib && m_mode != 0) begin
            h = t_sod / 3600; m = (t_sod / 60) % 60; s = t_sod % 60;
            if (m_mode == 1) h = (h + 1) % 24;
            if (m_mode == 2) m = (m + 1) % 60;
            if (m_mode == 3) s = (s + 1) % 60;
            t_sod = h * 3600 + m * 60 + s;
        end else if (m_mode == 0) begin
            if (m_pc == C_DIV - 1) begin
                m_pc   = 0;
                m_tick = 1;
                if (t_sod == 86399) m_wrap = 1;
                t_sod = (t_sod + 1) % 86400;
            end else begin
                m_pc++;
            end
        end
    endtask

    // Drive inputs, take one edge, update model, check all outputs.
    task automatic cyc(input bit mb, input bit ib, input bit ld,
                       input int lh, input int lm, input int ls, input string tag);
        mode_btn = mb; inc_btn = ib; load = ld;
        load_h = 5'(lh); load_m = 6'(lm); load_s = 6'(ls);
        @(posedge clk);
        model_step(mb, ib, ld, lh, lm, ls);
        #1;
        mode_btn = 1'b0; inc_btn = 1'b0; load = 1'b0;
        cyc_no++;
        if (sec_tick === 1'b1) begin
            if (last_tick >= 0) chk({tag, ".tick_gap"}, 32'(cyc_no - last_tick), C_DIV);
            last_tick = cyc_no;
            n_tick++;
        end
        if (day_wrap === 1'b1) n_wrap++;
        chk_all(tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, tag);
    endtask

    initial begin
        cyc_no = 0; last_tick = -1; n_tick = 0; n_wrap = 0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        chk_all("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // 1: 240 cycles -> 00:01:00, 60 ticks 4 apart
        idle(240, "run1m");
        chk("run1m.ticks", 32'(n_tick), 60);
        chk("run1m.h", 32'(hours), 0);
        chk("run1m.m", 32'(minutes), 1);
        chk("run1m.s", 32'(seconds), 0);

        // 2: day wrap
        cyc(0, 0, 1, 23, 59, 58, "load_wrap");
        last_tick = -1;
        n_wrap = 0;
        idle(7, "wrap");
        chk("wrap.before", 32'(day_wrap), 0);
        idle(1, "wrap");
        chk("wrap.pulse", 32'(day_wrap), 1);
        chk("wrap.count", 32'(n_wrap), 1);
        chk("wrap.time", 32'({hours, minutes, seconds}), 0);

        // 3: set hours with 25 increments
        cyc(1, 0, 0, 0, 0, 0, "seth.enter");
        n_tick = 0;
        for (int i = 0; i < 25; i++) cyc(0, 1, 0, 0, 0, 0, "seth.inc");
        idle(10, "seth.idle");
        chk("seth.hours", 32'(hours), 1);
        chk("seth.notick", 32'(n_tick), 0);
        cyc(1, 0, 0, 0, 0, 0, "setm.enter");
        cyc(1, 1, 0, 0, 0, 0, "sets.enter_inc");
        cyc(0, 1, 0, 0, 0, 0, "sets.inc");
        cyc(1, 0, 0, 0, 0, 0, "run.enter");
        last_tick = cyc_no;
        idle(C_DIV, "run.first_tick");
        chk("run.first_tick", 32'(sec_tick), 1);

        // 4: rejected presets
        cyc(0, 0, 1, 24, 0, 0, "err.h24");
        cyc(0, 0, 1, 12, 60, 0, "err.m60");
        cyc(0, 0, 1, 0, 0, 63, "err.s63");

        // 5: load wins over mode_btn
        cyc(1, 0, 1, 10, 20, 30, "load_mode");
        chk("load_mode.mode", 32'(mode), 0);
        last_tick = -1;
        idle(9, "after_load");

        // random phase
        last_tick = -1;
        for (int i = 0; i < 2000; i++) begin
            bit mb, ib, ld;
            int lh, lm, ls;
            mb = ($urandom_range(0, 29) == 0);
            ib = ($urandom_range(0, 3) == 0);
            ld = ($urandom_range(0, 39) == 0);
            lh = $urandom_range(0, 26);
            lm = $urandom_range(0, 62);
            ls = $urandom_range(0, 62);
            if (ld || mb) last_tick = -1;
            cyc(mb, ib, ld, lh, lm, ls, "rand");
        end
        // get back to RUN near midnight and roll over
        while (m_mode != 0) cyc(1, 0, 0, 0, 0, 0, "rand.exit");
        cyc(0, 0, 1, 23, 59, 59, "rand.late");
        last_tick = -1;
        idle(8, "rand.roll");

        // 6: asynchronous reset mid-cycle
        cyc(0, 0, 1, 7, 8, 9, "pre_areset");
        idle(2, "pre_areset");
        @(posedge clk);
        model_step(0, 0, 0, 0, 0, 0);
        #3;
        reset_n = 1'b0;
        #1;
        model_reset();
        chk_all("areset");
        @(negedge clk);
        reset_n = 1'b1;
        last_tick = -1;
        idle(C_DIV * 2, "post_areset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // global watchdog
    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
